// File: rtl/display_scan_ctrl_if.sv
// rtl/display_scan_ctrl_if.sv - load/value and digit-drive signal bundle for display_scan_ctrl
interface display_scan_ctrl_if;
    logic [15:0] value_in;
    logic        load;
    logic [1:0]  anode_driver;
    logic        digit_valid;
    logic [3:0]  nibble_out;
    logic        frame_tick;
    logic        pending;

    modport master (
        output value_in, load,
        input  anode_driver, digit_valid, nibble_out, frame_tick, pending
    );

    modport slave (
        input  value_in, load,
        output anode_driver, digit_valid, nibble_out, frame_tick, pending
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// rtl/display_scan_ctrl.sv - 4-digit seven-segment scan with dead time and frame-synchronous shadow commit
// Optional: LEADING_ZERO_BLANK_EN suppresses leading-zero digits above digit 0.
module display_scan_ctrl #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    display_scan_ctrl_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t           state, state_nxt;
    logic [1:0]       digit, digit_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [BLK_W-1:0] blank_cnt, blank_cnt_nxt;
    logic [15:0]      disp_reg;
    logic [15:0]      shadow;
    logic             pending_q;
    logic             commit;
    logic             lit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_BLANK;
            digit     <= 2'd0;
            div_cnt   <= '0;
            blank_cnt <= '0;
            disp_reg  <= 16'h0000;
            shadow    <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            digit     <= digit_nxt;
            div_cnt   <= div_cnt_nxt;
            blank_cnt <= blank_cnt_nxt;
            // disp_reg samples the old shadow, so a same-cycle load stays pending for the next frame
            if (commit && pending_q) begin
                disp_reg <= shadow;
            end
            if (bus.load) begin
                shadow    <= bus.value_in;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        digit_nxt     = digit;
        div_cnt_nxt   = div_cnt;
        blank_cnt_nxt = blank_cnt;
        commit        = 1'b0;
        lit           = 1'b0;
        case (state)
            S_BLANK: begin
                if (blank_cnt == BLK_LAST) begin
                    blank_cnt_nxt = '0;
                    state_nxt     = S_SHOW;
                end else begin
                    blank_cnt_nxt = blank_cnt + BLK_W'(1);
                end
            end
            S_SHOW: begin
                lit = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    digit_nxt   = digit + 2'd1;
                    state_nxt   = S_BLANK;
                    commit      = (digit == 2'd3);
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: state_nxt = S_BLANK;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // nz_above[d] is set when any nibble from d up to 3 is non-zero; digit 0 always lights
    logic [3:0] nz_above;
    always_comb begin
        nz_above    = 4'b0000;
        nz_above[3] = (|disp_reg[15:12]);
        nz_above[2] = nz_above[3] | (|disp_reg[11:8]);
        nz_above[1] = nz_above[2] | (|disp_reg[7:4]);
        nz_above[0] = 1'b1;
    end
    assign bus.digit_valid = lit && nz_above[digit];
`else
    assign bus.digit_valid = lit;
`endif

    assign bus.anode_driver = digit;
    assign bus.nibble_out   = disp_reg[{digit, 2'b00} +: 4];
    assign bus.frame_tick   = commit;
    assign bus.pending      = pending_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb/tb_display_scan_ctrl.sv - directed and random checks of display_scan_ctrl against a frame-position model
module tb_display_scan_ctrl;
    localparam int CD   = 4;
    localparam int BC   = 2;
    localparam int SLOT = CD + BC;
    localparam int PER  = 4 * SLOT;

    logic clk = 1'b0;
    logic reset;

    display_scan_ctrl_if bus();

    display_scan_ctrl #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: cycles since reset release plus the displayed/shadow values
    int        t = 0;
    bit [15:0] m_disp = 16'h0;
    bit [15:0] m_shadow = 16'h0;
    bit        m_pend = 1'b0;

    function automatic int e_digit();
        return (t % PER) / SLOT;
    endfunction

    function automatic bit e_lit();
        return (t % SLOT) >= BC;
    endfunction

    function automatic bit e_tick();
        return (t % PER) == PER - 1;
    endfunction

    function automatic bit e_valid();
        int d = e_digit();
        if (!e_lit()) return 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (d != 0 && (m_disp >> (4 * d)) == 16'h0) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic [3:0] e_nib();
        return 4'((m_disp >> (4 * e_digit())) & 16'hF);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Drive one clock of inputs, advance the model, then check outputs at the following negedge
    task automatic tick(input bit rst, input bit ld, input logic [15:0] v);
        reset        = rst;
        bus.load     = ld;
        bus.value_in = v;
        if (rst) begin
            t = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
        end else begin
            if (e_tick() && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_shadow = v;
                m_pend   = 1'b1;
            end
            t++;
        end
        @(negedge clk);
        chk("anode_driver", 16'(bus.anode_driver), 16'(e_digit()));
        chk("digit_valid",  16'(bus.digit_valid),  16'(e_valid()));
        chk("nibble_out",   16'(bus.nibble_out),   16'(e_nib()));
        chk("frame_tick",   16'(bus.frame_tick),   16'(e_tick()));
        chk("pending",      16'(bus.pending),      16'(m_pend));
    endtask

    task automatic goto_pos(input int pos);
        for (int n = 0; n <= PER && (t % PER) != pos; n++) tick(1'b0, 1'b0, 16'h0);
    endtask

    // Assumes frame position 0; lit_mask selects which digits are expected lit
    task automatic check_frame_valid(input string tag, input bit [3:0] lit_mask);
        for (int i = 0; i < PER; i++) begin
            chk(tag, 16'(bus.digit_valid), 16'(((i % SLOT) >= BC) && lit_mask[i / SLOT]));
            tick(1'b0, 1'b0, 16'h0);
        end
    endtask

    task automatic check_frame_nibbles(input string tag, input logic [15:0] val, input bit pend);
        for (int i = 0; i < PER; i++) begin
            chk({tag, "_nib"},  16'(bus.nibble_out), (val >> (4 * (i / SLOT))) & 16'hF);
            chk({tag, "_pend"}, 16'(bus.pending),    16'(pend));
            tick(1'b0, 1'b0, 16'h0);
        end
    endtask

    initial begin
        int last_tick;
        int n_ticks;
        int n;
        bit [3:0] lz_40;
        bit [3:0] lz_00;

        reset        = 1'b1;
        bus.load     = 1'b0;
        bus.value_in = 16'h0;
        @(negedge clk);

        // Reset held 3 cycles, then the opening blank/lit/blank pattern
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'h0);
        chk("rst_anode",   16'(bus.anode_driver), 16'h0);
        chk("rst_valid",   16'(bus.digit_valid),  16'h0);
        chk("rst_nibble",  16'(bus.nibble_out),   16'h0);
        chk("rst_tick",    16'(bus.frame_tick),   16'h0);
        chk("rst_pending", 16'(bus.pending),      16'h0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(1'b0, 1'b0, 16'h0);
            chk("open_anode", 16'(bus.anode_driver), (i < 6) ? 16'h0 : 16'h1);
            chk("open_valid", 16'(bus.digit_valid),  (i >= 2 && i < 6) ? 16'h1 : 16'h0);
        end

        // Free run: frame_tick every PER cycles on the last lit cycle of digit 3
        last_tick = -1;
        n_ticks   = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'b0, 16'h0);
            if (bus.frame_tick === 1'b1) begin
                chk("tick_anode", 16'(bus.anode_driver), 16'h3);
                chk("tick_valid", 16'(bus.digit_valid),  16'h1);
                if (last_tick >= 0) chk("tick_period", 16'(t - last_tick), 16'(PER));
                last_tick = t;
                n_ticks++;
            end
        end
        chk("tick_count", 16'(n_ticks), 16'h2);

        // Load during digit 1; display stays 0 until the commit
        goto_pos(SLOT + 1);
        tick(1'b0, 1'b1, 16'h1234);
        chk("load_pending", 16'(bus.pending), 16'h1);
        n = 0;
        while (bus.frame_tick !== 1'b1 && n < PER) begin
            chk("hold_nibble", 16'(bus.nibble_out), 16'h0);
            tick(1'b0, 1'b0, 16'h0);
            n++;
        end
        chk("commit_seen", 16'(bus.frame_tick), 16'h1);
        tick(1'b0, 1'b0, 16'h0);
        check_frame_nibbles("f1234", 16'h1234, 1'b0);

        // Load on the commit cycle: old shadow shows first, new one a frame later
        tick(1'b0, 1'b1, 16'hAAAA);
        goto_pos(PER - 1);
        chk("coinc_tick", 16'(bus.frame_tick), 16'h1);
        tick(1'b0, 1'b1, 16'h5555);
        check_frame_nibbles("fAAAA", 16'hAAAA, 1'b1);
        check_frame_nibbles("f5555", 16'h5555, 1'b0);

        // Reset during digit 2 lit abandons the display
        tick(1'b0, 1'b1, 16'hBEEF);
        goto_pos(0);
        goto_pos(2 * SLOT + BC);
        chk("beef_digit2", 16'(bus.nibble_out), 16'hE);
        tick(1'b1, 1'b0, 16'h0);
        chk("mid_rst_anode",   16'(bus.anode_driver), 16'h0);
        chk("mid_rst_valid",   16'(bus.digit_valid),  16'h0);
        chk("mid_rst_nibble",  16'(bus.nibble_out),   16'h0);
        chk("mid_rst_pending", 16'(bus.pending),      16'h0);
        check_frame_nibbles("f_after_rst", 16'h0000, 1'b0);

        // Leading-zero blanking
`ifdef LEADING_ZERO_BLANK_EN
        lz_40 = 4'b0011;
        lz_00 = 4'b0001;
`else
        lz_40 = 4'b1111;
        lz_00 = 4'b1111;
`endif
        tick(1'b0, 1'b1, 16'h0040);
        goto_pos(0);
        check_frame_valid("lz_0040", lz_40);
        tick(1'b0, 1'b1, 16'h0000);
        goto_pos(0);
        check_frame_valid("lz_0000", lz_00);

        // Random loads and occasional resets against the model
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            case ($urandom_range(0, 3))
                0: v[15:8] = 8'h00;
                1: v[15:4] = 12'h000;
                default: ;
            endcase
            tick(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Scan controller for the 4-digit seven-segment display. It produces the 2-bit anode_driver code that feeds anode_mux, the 4-bit nibble for the segment decoder, and a digit_valid qualifier. A dead-time interval between digits prevents ghosting. A shadow register is committed only at frame boundaries, so a displayed value never tears.

Parameters:
CLK_DIV, 100000, clocks each digit stays lit (must be >= 1)
BLANK_CYCLES, 16, dead-time clocks before each digit is lit (must be >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
value_in  input  16  four hex nibbles; [3:0] is digit 0, [15:12] is digit 3
load  input  1  single-cycle strobe; captures value_in into the shadow register
anode_driver  output  2  index of the current digit, drives anode_mux
digit_valid  output  1  1 = the selected digit is lit; 0 = blank/dead time
nibble_out  output  4  display nibble for the current digit
frame_tick  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0
pending  output  1  1 = shadow holds a value not yet displayed

Behaviour:
- One clock (clk). Reset is synchronous and active-high. All state is registered. Outputs are decoded from registers only; there is no combinational path from any input to any output.
- State: state {S_BLANK, S_SHOW}, digit[1:0], div_cnt, blank_cnt, disp_reg[15:0], shadow[15:0], pending.
- Reset values: state=S_BLANK, digit=0, div_cnt=0, blank_cnt=0, disp_reg=0, shadow=0, pending=0.
  - Resulting outputs: anode_driver=0, digit_valid=0, nibble_out=0, frame_tick=0, pending=0.
- Reset mid-operation: abandons the scan and any pending value. The next cycle shows reset values.
- S_BLANK:
  - digit_valid=0; blank_cnt increments.
  - When blank_cnt==BLANK_CYCLES-1: blank_cnt<=0, go to S_SHOW.
- S_SHOW:
  - digit_valid=1; div_cnt increments.
  - When div_cnt==CLK_DIV-1: div_cnt<=0, digit<=digit+1 (3 wraps to 0), go to S_BLANK.
- Outputs:
  - anode_driver=digit.
  - nibble_out=disp_reg[4*digit+3 : 4*digit], in both states.
- Timing after reset release:
  - S_BLANK for BLANK_CYCLES cycles, then digit 0 lit for CLK_DIV cycles, then repeat per digit.
  - Frame period = 4*(CLK_DIV+BLANK_CYCLES) clocks.
- Commit (the terminal S_SHOW cycle of digit 3):
  - frame_tick=1 for that one cycle.
  - If pending=1: disp_reg<=shadow and pending<=0, visible from digit 0 of the next frame.
- Load:
  - load=1 in any non-reset cycle: shadow<=value_in, pending<=1.
  - Load while pending: shadow is overwritten; last write wins.
- Simultaneous load and commit:
  - disp_reg takes the OLD shadow.
  - shadow takes value_in and pending stays 1. The new value displays one frame later.
- Reset has priority over load and commit.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: in S_SHOW, digit_valid=0 for any digit d>0 where disp_reg nibbles d..3 are all zero. Digit 0 is always lit, so value 0 shows a single "0". Scan timing, anode_driver and nibble_out are unchanged.
- Undefined: all four digits are lit in S_SHOW regardless of value.

Test Plan:
All scenarios use CLK_DIV=4, BLANK_CYCLES=2.
1. Reset held 3 cycles, then released -> anode_driver=0, digit_valid=0 for 2 cycles, then 1 for 4 cycles, then anode_driver=1 with digit_valid=0 for 2 cycles.
2. Free run for 50 cycles -> anode_driver sequence 0,1,2,3,0 with 6 clocks per digit; frame_tick pulses exactly every 24 cycles, on the last lit cycle of digit 3.
3. load=1 with value_in=16'h1234 at digit 1 of a frame -> pending=1 immediately; nibble_out stays 0 until frame_tick; next frame shows nibble_out=4,3,2,1 for digits 0..3; pending=0 after commit.
4. Shadow=16'hAAAA with pending=1; load 16'h5555 on the frame_tick cycle -> next frame displays A on all digits with pending=1; following frame displays 5 on all digits with pending=0.
5. Load 16'hBEEF, wait for it to display, then assert reset during S_SHOW of digit 2 -> next cycle anode_driver=0, digit_valid=0, nibble_out=0, pending=0; the next frame displays 0000.
6. LEADING_ZERO_BLANK_EN defined, display 16'h0040 -> digit_valid=0 while digits 3 and 2 are selected, 1 for digits 1 and 0. Display 16'h0000 -> only digit 0 lit. Macro undefined -> all four digits lit in both cases.
